// File: rtl/framebuffer_writer_pkg.sv
// ============================================================================
// Module : framebuffer_writer_pkg
// Brief  : Shared types and frame constants for the framebuffer writer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package framebuffer_writer_pkg;

    localparam int FB_FRAME_WIDTH  = 512;
    localparam int FB_FRAME_HEIGHT = 384;
    localparam int FB_ADDR_BITS    = 18;
    localparam int FB_COLOR_BITS   = 16;
    localparam int FB_NUM_PIXELS   = FB_FRAME_WIDTH * FB_FRAME_HEIGHT;

    typedef logic [FB_ADDR_BITS-1:0] FbAddr;

    typedef struct packed {
        FbAddr                    addr;
        logic [FB_COLOR_BITS-1:0] pixel;
    } FbEntry;

    typedef enum logic [1:0] {
        FB_RUN   = 2'd0,
        FB_DRAIN = 2'd1,
        FB_CLEAR = 2'd2
    } FbState;

endpackage

`default_nettype wire

// File: rtl/fb_sync_fifo.sv
// ============================================================================
// Module : fb_sync_fifo
// Brief  : Single-clock FIFO, pointer-plus-wrap-bit full/empty, show-ahead.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [PTR_BITS:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    // Equal indices: the wrap bit tells full (differs) from empty (matches).
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                       (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = mem_q[rd_ptr_q[PTR_BITS-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + (PTR_BITS+1)'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + (PTR_BITS+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[PTR_BITS-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/framebuffer_writer.sv
// ============================================================================
// Module : framebuffer_writer
// Brief  : Queues pixel results, forms frame addresses and drives BRAM writes;
//          runs a full-frame clear on command. Optional stats: FB_WRITER_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int FRAME_WIDTH  = FB_FRAME_WIDTH,
    parameter int FRAME_HEIGHT = FB_FRAME_HEIGHT,
    parameter int COORD_BITS   = 16,
    parameter int ADDR_BITS    = FB_ADDR_BITS,
    parameter int COLOR_BITS   = FB_COLOR_BITS,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COORD_BITS-1:0] in_x,
    input  logic [COORD_BITS-1:0] in_y,
    input  logic [COLOR_BITS-1:0] in_pixel,
    input  logic                  clear_req,
    input  logic [COLOR_BITS-1:0] clear_color,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  bram_we,
    output logic [ADDR_BITS-1:0]  bram_addr,
    output logic [COLOR_BITS-1:0] bram_din
`ifdef FB_WRITER_STATS_EN
    ,
    output logic [15:0]           drop_count,
    output logic [31:0]           write_count
`endif
);

    localparam int                   X_BITS    = $clog2(FRAME_WIDTH);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);

    FbState                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [COLOR_BITS-1:0] color_q, color_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  clear_done_q, clear_done_d;
    logic                  bram_we_q, bram_we_d;
    logic [ADDR_BITS-1:0]  bram_addr_q, bram_addr_d;
    logic [COLOR_BITS-1:0] bram_din_q, bram_din_d;

    FbEntry                w_entry;
    logic [$bits(FbEntry)-1:0] w_fifo_dout;
    FbEntry                w_head;
    logic                  w_fifo_full, w_fifo_empty;
    logic                  w_accept, w_in_range, w_push, w_pop, w_clear_acc;
    logic [ADDR_BITS-1:0]  w_addr;

    assign in_ready    = rdy_q && (state_q == FB_RUN) && !w_fifo_full;
    assign busy        = (state_q != FB_RUN) || !w_fifo_empty;
    assign w_accept    = in_valid && in_ready;
    assign w_in_range  = (32'(in_x) < FRAME_WIDTH) && (32'(in_y) < FRAME_HEIGHT);
    assign w_push      = w_accept && w_in_range;
    assign w_pop       = !w_fifo_empty;
    assign w_clear_acc = clear_req && (state_q == FB_RUN);
    assign w_addr      = (ADDR_BITS'(in_y) << X_BITS) | ADDR_BITS'(in_x);
    assign w_entry     = '{addr: FB_ADDR_BITS'(w_addr), pixel: FB_COLOR_BITS'(in_pixel)};
    assign w_head      = FbEntry'(w_fifo_dout);

    fb_sync_fifo #(
        .WIDTH ($bits(FbEntry)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_entry),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        rdy_d        = 1'b1;
        color_d      = color_q;
        cnt_d        = cnt_q;
        last_d       = 1'b0;
        clear_done_d = last_q;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        if (w_pop) begin
            bram_we_d   = 1'b1;
            bram_addr_d = ADDR_BITS'(w_head.addr);
            bram_din_d  = COLOR_BITS'(w_head.pixel);
        end
        case (state_q)
            FB_RUN: begin
                if (w_clear_acc) begin
                    color_d = clear_color;
                    cnt_d   = '0;
                    // A pixel pushed alongside the request must land before the clear.
                    state_d = (!w_fifo_empty || w_push) ? FB_DRAIN : FB_CLEAR;
                end
            end
            FB_DRAIN: begin
                if (w_fifo_empty) state_d = FB_CLEAR;
            end
            FB_CLEAR: begin
                bram_we_d   = 1'b1;
                bram_addr_d = cnt_q;
                bram_din_d  = color_q;
                cnt_d       = cnt_q + ADDR_BITS'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = FB_RUN;
                    last_d  = 1'b1;
                end
            end
            default: state_d = FB_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FB_RUN;
            rdy_q        <= 1'b0;
            color_q      <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            clear_done_q <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            rdy_q        <= rdy_d;
            color_q      <= color_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            clear_done_q <= clear_done_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
        end
    end

    assign clear_done = clear_done_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_din   = bram_din_q;

`ifdef FB_WRITER_STATS_EN
    logic [15:0] drop_q, drop_d;
    logic [31:0] wcnt_q, wcnt_d;

    always_comb begin
        drop_d = drop_q;
        wcnt_d = wcnt_q;
        if (w_accept && !w_in_range && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        if (w_pop) wcnt_d = wcnt_q + 32'd1;
        if (w_clear_acc) begin
            drop_d = '0;
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            wcnt_q <= '0;
        end else begin
            drop_q <= drop_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign drop_count  = drop_q;
    assign write_count = wcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
// ============================================================================
// Module : tb_framebuffer_writer
// Brief  : Scoreboard bench for framebuffer_writer on a reduced 64x40 frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_framebuffer_writer;

    localparam int FW = 64;
    localparam int FH = 40;
    localparam int NP = FW * FH;

    typedef struct {
        int          addr;
        logic [15:0] data;
        bit          clr;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x, in_y, in_pixel;
    logic        clear_req;
    logic [15:0] clear_color;
    logic        busy, clear_done, bram_we;
    logic [17:0] bram_addr;
    logic [15:0] bram_din;
`ifdef FB_WRITER_STATS_EN
    logic [15:0] drop_count;
    logic [31:0] write_count;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    bit   clearing = 0;
    bit   done_pending = 0;
    bit   seen_1000 = 0;

    always #5 clk = ~clk;

    framebuffer_writer #(
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_pixel    (in_pixel),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .busy        (busy),
        .clear_done  (clear_done),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din)
`ifdef FB_WRITER_STATS_EN
        ,
        .drop_count  (drop_count),
        .write_count (write_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: every accepted in-range pixel becomes one write; an
    // accepted clear becomes NP writes of the colour, in address order.
    initial forever begin
        @(posedge clk);
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready && (in_x < FW) && (in_y < FH))
                exp_q.push_back('{addr: int'(in_y) * FW + int'(in_x), data: in_pixel, clr: 1'b0, last: 1'b0});
            if (clear_req && !clearing) begin
                clearing = 1'b1;
                for (int a = 0; a < NP; a++)
                    exp_q.push_back('{addr: a, data: clear_color, clr: 1'b1, last: (a == NP - 1)});
            end
        end
    end

    // Monitor: compare every BRAM write and every clear_done against the model.
    initial forever begin
        bit   exp_done;
        exp_t e;
        @(negedge clk);
        if (rst_n === 1'b1) begin
            exp_done     = done_pending;
            done_pending = 1'b0;
            if (clear_done || exp_done) chk("clear_done", 32'(clear_done), 32'(exp_done));
            if (clear_done) done_count++;
            if (bram_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(bram_addr), 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(bram_addr), 32'(e.addr));
                    chk("write_data", 32'(bram_din), 32'(e.data));
                    if (e.clr && !e.last) begin
                        chk("ready_in_clear", 32'(in_ready), 32'd0);
                        chk("busy_in_clear", 32'(busy), 32'd1);
                    end
                    if (e.clr && e.addr == 1000) seen_1000 = 1'b1;
                    if (e.last) begin
                        done_pending = 1'b1;
                        clearing     = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clear(input logic [15:0] color);
        clear_req   = 1'b1;
        clear_color = color;
        @(negedge clk);
        clear_req   = 1'b0;
        clear_color = 16'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_pixel = '0;
        clear_req = 1'b0; clear_color = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(bram_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(in_ready), 32'd1);

        // Single pixel latency
        in_valid = 1'b1; in_x = 16'd3; in_y = 16'd2; in_pixel = 16'h0ABC;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_cycle_n", 32'(bram_we), 32'd0);
        @(negedge clk);
        chk("lat_cycle_n1_we", 32'(bram_we), 32'd1);
        chk("lat_cycle_n1_addr", 32'(bram_addr), 32'(2 * FW + 3));
        chk("lat_cycle_n1_din", 32'(bram_din), 32'h0ABC);
        @(negedge clk);
        chk("lat_after_we", 32'(bram_we), 32'd0);

        // Back-to-back burst
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_x = 16'(i); in_y = 16'd7; in_pixel = 16'($urandom);
            #1 chk("burst_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_drain(50);

        // Out-of-range pixels are accepted but never written
        in_valid = 1'b1; in_x = 16'(FW); in_y = 16'd0; in_pixel = 16'h1111;
        @(negedge clk);
        in_x = 16'd0; in_y = 16'(FH); in_pixel = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain(20);
`ifdef FB_WRITER_STATS_EN
        chk("drop_count", 32'(drop_count), 32'd2);
`endif

        // Randomized traffic including out-of-range coordinates
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_x     = 16'($urandom_range(0, FW + 3));
            in_y     = 16'($urandom_range(0, FH + 2));
            in_pixel = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_drain(50);

        // Five pixels, clear requested with the last one; pixels offered during clear
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x = 16'($urandom_range(0, FW - 1)); in_y = 16'($urandom_range(0, FH - 1));
            in_pixel = 16'($urandom);
            if (i == 4) begin clear_req = 1'b1; clear_color = 16'h0F00; end
            @(negedge clk);
        end
        in_valid = 1'b0; clear_req = 1'b0; clear_color = 16'hDEAD;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_x = 16'd1; in_y = 16'd1; in_pixel = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_drain(NP + 100);
        chk("done_count_1", 32'(done_count), 32'd1);

        // A second request mid-clear is ignored
        pulse_clear(16'h1234);
        repeat (100) @(negedge clk);
        pulse_clear(16'hFFFF);
        wait_drain(NP + 100);
        chk("done_count_2", 32'(done_count), 32'd2);

        // Pixel and clear in the same cycle: pixel first, then overwritten
        in_valid = 1'b1; in_x = 16'd10; in_y = 16'd5; in_pixel = 16'hBEEF;
        pulse_clear(16'h5A5A);
        in_valid = 1'b0;
        wait_drain(NP + 100);
        chk("done_count_3", 32'(done_count), 32'd3);

        // Reset in the middle of a clear
        pulse_clear(16'h0777);
        for (int i = 0; i < 2000; i++) begin
            if (seen_1000) break;
            @(negedge clk);
        end
        chk("reached_addr_1000", 32'(seen_1000), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(bram_we), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd0);
        chk("async_rst_addr", 32'(bram_addr), 32'd0);
        exp_q.delete();
        clearing = 1'b0; done_pending = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_x = 16'd0; in_y = 16'd0; in_pixel = 16'h1357;
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain(20);
        chk("done_count_after_rst", 32'(done_count), 32'd3);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
